// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit -- PC register and instruction-fetch sequencer.
//
// Holds the architectural PC, drives pc_plus4 back to next_pc_mux and
// fetches one instruction at a time over a valid/ready request channel and
// a valid-only response channel. The fetched word is held for decode until
// decode accepts it, at which point the PC is loaded from pc_next.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a misaligned pc_next on accept sets a sticky fetch_misalign
//               flag and parks the unit in S_TRAP until rst.
//   undefined : pc_next is force-aligned to a word boundary; fetch_misalign
//               is tied 0.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   pc_next           next PC from next_pc_mux (sampled on decode accept)
//   pc, pc_plus4      current PC and PC+4 (wraps modulo 2^32)
//   imem_req_valid/ready, imem_addr    fetch request channel
//   imem_rsp_valid, imem_rsp_data      fetch response channel
//   instr_valid/ready, instr, instr_pc held instruction for decode
//   fetch_misalign    sticky misaligned-target flag
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_next,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        fetch_misalign
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
`ifdef FETCH_MISALIGN_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  state_t state, state_nxt;

  logic accept;
  logic load_pc;
  logic [31:0] pc_load_val;

  assign accept = (state == S_HOLD) && instr_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_hit;
  assign misalign_hit = accept && (pc_next[1:0] != 2'b00);
  // A misaligned target is not loaded; pc keeps the address of the last
  // accepted instruction so the trap handler can see where it came from.
  assign load_pc     = accept && !misalign_hit;
  assign pc_load_val = pc_next;
`else
  logic unused_pc_next_lsbs;
  assign unused_pc_next_lsbs = ^pc_next[1:0];
  assign load_pc     = accept;
  assign pc_load_val = {pc_next[31:2], 2'b00};
`endif

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: state_nxt is given a default before the case so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ:  if (imem_req_ready) state_nxt = S_WAIT;
      S_WAIT: if (imem_rsp_valid) state_nxt = S_HOLD;
      S_HOLD: begin
        if (instr_ready) begin
`ifdef FETCH_MISALIGN_TRAP_EN
          state_nxt = misalign_hit ? S_TRAP : S_REQ;
`else
          state_nxt = S_REQ;
`endif
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      S_TRAP: state_nxt = S_TRAP;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // PC and held-instruction registers. The response is only captured in
  // S_WAIT, so a late response after a reset is dropped naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      instr    <= 32'h0;
      instr_pc <= 32'h0;
    end else begin
      if ((state == S_WAIT) && imem_rsp_valid) begin
        instr    <= imem_rsp_data;
        instr_pc <= pc;
      end
      if (load_pc) pc <= pc_load_val;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst)               fetch_misalign <= 1'b0;
    else if (misalign_hit) fetch_misalign <= 1'b1;
  end
`else
  assign fetch_misalign = 1'b0;
`endif

  // Outputs decoded from state and registers only.
  assign imem_req_valid = (state == S_REQ);
  assign instr_valid    = (state == S_HOLD);
  assign imem_addr      = pc;
  assign pc_plus4       = pc + 32'd4;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_next = 32'h0;
  logic [31:0] pc, pc_plus4, imem_addr, instr, instr_pc;
  logic        imem_req_valid, instr_valid, fetch_misalign;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        instr_ready = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .pc_next(pc_next), .pc(pc), .pc_plus4(pc_plus4),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .fetch_misalign(fetch_misalign)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Advance one cycle; outputs are sampled 1 time unit after the edge and
  // inputs changed here are seen at the following edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got=%b exp=0", imem_req_valid); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_instr_valid got=%b exp=0", instr_valid); end
    checks++; if (pc !== RST_PC) begin errors++; $display("FAIL rst_pc got=%h exp=%h", pc, RST_PC); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr got=%h exp=0", instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rst_instr_pc got=%h exp=0", instr_pc); end
    checks++; if (fetch_misalign !== 1'b0) begin errors++; $display("FAIL rst_misalign got=%b exp=0", fetch_misalign); end
    rst = 1'b0;
    // Still S_IDLE in the first cycle after release.
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL idle_req_valid got=%b exp=0", imem_req_valid); end
    step();
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid got=%b exp=1", imem_req_valid); end
    checks++; if (imem_addr !== RST_PC) begin errors++; $display("FAIL first_addr got=%h exp=%h", imem_addr, RST_PC); end
    checks++; if (pc_plus4 !== 32'h104) begin errors++; $display("FAIL first_pc_plus4 got=%h exp=104", pc_plus4); end
  endtask

  // Full fetch with no backpressure; starts and ends in S_REQ.
  task automatic fetch_one(input logic [31:0] exp_addr, input logic [31:0] data,
                           input logic [31:0] nxt);
    checks++; if (imem_addr !== exp_addr) begin errors++; $display("FAIL f1_addr got=%h exp=%h", imem_addr, exp_addr); end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    step();
    imem_rsp_valid = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instr !== data) begin errors++; $display("FAIL f1_hold got v=%b i=%h exp v=1 i=%h", instr_valid, instr, data); end
    instr_ready = 1'b1;
    pc_next     = nxt;
    step();
    instr_ready = 1'b0;
  endtask

  task automatic test_sequential();
    int t0;
    t0 = cyc;
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL seq_wait got rv=%b iv=%b exp 0 0", imem_req_valid, instr_valid); end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0050_0093;
    step();
    imem_rsp_valid = 1'b0;
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL seq_instr_valid got=%b exp=1", instr_valid); end
    checks++; if (instr !== 32'h0050_0093) begin errors++; $display("FAIL seq_instr got=%h exp=00500093", instr); end
    checks++; if (instr_pc !== 32'h100) begin errors++; $display("FAIL seq_instr_pc got=%h exp=100", instr_pc); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL seq_hold_req got=%b exp=0", imem_req_valid); end
    instr_ready = 1'b1;
    pc_next     = 32'h104;
    step();
    instr_ready = 1'b0;
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h104) begin errors++; $display("FAIL seq_next_req got v=%b a=%h exp v=1 a=104", imem_req_valid, imem_addr); end
    checks++; if (cyc - t0 !== 3) begin errors++; $display("FAIL seq_latency got=%0d exp=3", cyc - t0); end
  endtask

  task automatic test_backpressure();
    // Stray responses while in S_REQ must not be captured.
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h104) begin errors++; $display("FAIL bp_req_hold%0d got v=%b a=%h exp v=1 a=104", i, imem_req_valid, imem_addr); end
    end
    checks++; if (instr !== 32'h0050_0093) begin errors++; $display("FAIL bp_stray_rsp got=%h exp=00500093", instr); end
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h00A0_0113;
    step();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1234_5678;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (instr_valid !== 1'b1 || instr !== 32'h00A0_0113 || instr_pc !== 32'h104) begin errors++; $display("FAIL bp_hold%0d got v=%b i=%h p=%h exp v=1 i=00a00113 p=104", i, instr_valid, instr, instr_pc); end
    end
    imem_rsp_valid = 1'b0;
    instr_ready    = 1'b1;
    pc_next        = 32'h200;
    step();
    instr_ready = 1'b0;
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL redirect got v=%b a=%h exp v=1 a=200", imem_req_valid, imem_addr); end
  endtask

  task automatic test_wrap();
    fetch_one(32'h200, 32'h0000_0013, 32'hFFFF_FFFC);
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got=%h exp=fffffffc", imem_addr); end
    checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc_plus4 got=%h exp=0", pc_plus4); end
  endtask

  task automatic test_misalign();
    fetch_one(32'hFFFF_FFFC, 32'h0000_0033, 32'h202);
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      checks++; if (fetch_misalign !== 1'b1) begin errors++; $display("FAIL mis_flag%0d got=%b exp=1", i, fetch_misalign); end
      checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL mis_quiet%0d got rv=%b iv=%b exp 0 0", i, imem_req_valid, instr_valid); end
      checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL mis_pc%0d got=%h exp=fffffffc", i, pc); end
      imem_req_ready = 1'b1;
      instr_ready    = 1'b1;
      step();
    end
    imem_req_ready = 1'b0;
    instr_ready    = 1'b0;
`else
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL mis_align got v=%b a=%h exp v=1 a=200", imem_req_valid, imem_addr); end
    checks++; if (fetch_misalign !== 1'b0) begin errors++; $display("FAIL mis_flag got=%b exp=0", fetch_misalign); end
`endif
  endtask

  task automatic test_reset_mid_wait();
    test_reset();
    fetch_one(32'h100, 32'h0000_0001, 32'h300);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    // In S_WAIT now; reset abandons the request.
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL rw_idle got rv=%b iv=%b exp 0 0", imem_req_valid, instr_valid); end
    step();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_BAD0;
    step();
    imem_rsp_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rw_instr_valid got=%b exp=0", instr_valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rw_instr got=%h exp=0", instr); end
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== RST_PC) begin errors++; $display("FAIL rw_restart got v=%b a=%h exp v=1 a=%h", imem_req_valid, imem_addr, RST_PC); end
    fetch_one(RST_PC, 32'h0000_0002, 32'h104);
    checks++; if (instr_pc !== RST_PC || imem_addr !== 32'h104) begin errors++; $display("FAIL rw_refetch got p=%h a=%h exp p=%h a=104", instr_pc, imem_addr, RST_PC); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_wrap();
    test_misalign();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
